// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational N-bit adder slice with carry in/out
module adder_chunk #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - carry-pipelined add/sub unit with valid/ready handshake
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if (WIDTH % STAGES != 0) begin : g_width_check
        $fatal(1, "pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic             stall;
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] a_in    [STAGES];
    logic [WIDTH-1:0] b_in    [STAGES];
    logic [WIDTH-1:0] s_in    [STAGES];
    logic             c_in    [STAGES];
    logic             v_in    [STAGES];
    logic [CHUNK-1:0] op_a    [STAGES];
    logic [CHUNK-1:0] op_b    [STAGES];
    logic [CHUNK-1:0] chunk_s [STAGES];
    logic             chunk_c [STAGES];
    logic [WIDTH-1:0] s_d     [STAGES];
    logic             ovf_d;

    assign out_valid = v_q[LAST];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

    // Stage 0 works on the port operands; later stages on the previous stage's registers.
    always_comb begin
        a_in[0] = a;
        b_in[0] = sub ? ~b : b;
        s_in[0] = '0;
        c_in[0] = sub ? 1'b1 : cin;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            op_a[k] = a_in[k][k*CHUNK +: CHUNK];
            op_b[k] = b_in[k][k*CHUNK +: CHUNK];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_chunk
        adder_chunk #(.N(CHUNK)) u_chunk (
            .a  (op_a[g]),
            .b  (op_b[g]),
            .ci (c_in[g]),
            .s  (chunk_s[g]),
            .co (chunk_c[g])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_d[k] = s_in[k];
            s_d[k][k*CHUNK +: CHUNK] = chunk_s[k];
        end
        ovf_d = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                (s_d[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
    end

    // Data registers load only behind a valid beat so the outputs hold across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                if (v_in[k]) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= chunk_c[k];
                end
            end
            if (v_in[LAST]) begin
                ovf_q <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder
module tb_pipelined_adder;

    localparam int W = 8;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc_cyc;
        int           acc_stalls;
    } exp_t;

    exp_t         q[$];
    int           pass_cnt = 0;
    int           total = 0;
    int           cycle = 0;
    int           stalls = 0;
    logic         held = 1'b0;
    logic [W-1:0] h_sum;
    logic         h_cout;
    logic         h_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total = total + 1;
        assert (obs === expv) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Reference: plain unsigned/signed integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                   input logic vc, input logic vs, input int c, input int st);
        exp_t   e;
        longint ua, ub, sa, sbv, full, sres, lo, hi;
        ua   = longint'(va);
        ub   = longint'(vb);
        sa   = longint'($signed(va));
        sbv  = longint'($signed(vb));
        lo   = -(longint'(1) << (W - 1));
        hi   = (longint'(1) << (W - 1)) - 1;
        if (vs) begin
            full   = ua - ub;
            e.cout = (ua >= ub);
            sres   = sa - sbv;
        end else begin
            full   = ua + ub + longint'(vc);
            e.cout = (full >= (longint'(1) << W));
            sres   = sa + sbv + longint'(vc);
        end
        e.sum        = full[W-1:0];
        e.ovf        = (sres < lo) || (sres > hi);
        e.acc_cyc    = c;
        e.acc_stalls = st;
        return e;
    endfunction

    task automatic cyc(input logic v, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vc, input logic vs, input logic ordy);
        exp_t e;
        in_valid  = v;
        a         = va;
        b         = vb;
        cin       = vc;
        sub       = vs;
        out_ready = ordy;
        @(negedge clk);
        if (held) begin
            chk("held_valid", out_valid, 1);
            chk("held_sum", sum, h_sum);
            chk("held_cout", cout, h_cout);
            chk("held_ovf", ovf, h_ovf);
        end
        chk("in_ready", in_ready, !(out_valid && !ordy));
        if (out_valid && ordy) begin
            chk("beat_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sum", sum, e.sum);
                chk("cout", cout, e.cout);
                chk("ovf", ovf, e.ovf);
                chk("latency", cycle, e.acc_cyc + S + (stalls - e.acc_stalls));
            end
        end
        held   = out_valid && !ordy;
        h_sum  = sum;
        h_cout = cout;
        h_ovf  = ovf;
        if (v && in_ready) q.push_back(model(va, vb, vc, vs, cycle, stalls));
        if (out_valid && !ordy) stalls = stalls + 1;
        @(posedge clk);
        #1;
        cycle = cycle + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);

        // Directed beats, results land in cycles 4..7.
        cyc(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'h80, 8'h01, 1'b1, 1'b1, 1'b1);
        chk("d0_valid", out_valid, 1);
        chk("d0_sum", sum, 8'h00);
        chk("d0_cout", cout, 1);
        chk("d0_ovf", ovf, 0);
        idle(1);
        chk("d1_sum", sum, 8'h80);
        chk("d1_cout", cout, 0);
        chk("d1_ovf", ovf, 1);
        idle(1);
        chk("d2_sum", sum, 8'hFE);
        chk("d2_cout", cout, 0);
        chk("d2_ovf", ovf, 0);
        idle(1);
        chk("d3_sum", sum, 8'h7F);
        chk("d3_cout", cout, 1);
        chk("d3_ovf", ovf, 1);
        idle(S + 1);

        // 16 back-to-back random beats.
        for (int i = 0; i < 16; i++)
            cyc(1'b1, W'($urandom), W'($urandom), 1'(($urandom)), 1'(($urandom)), 1'b1);
        idle(S + 1);

        // Stream with output backpressure in relative cycles 6..9.
        for (int t = 0; t < 20; t++)
            cyc(t < 12, W'($urandom), W'($urandom), 1'(($urandom)), 1'(($urandom)),
                !(t >= 6 && t <= 9));
        idle(S + 1);

        // Asynchronous reset with three beats in flight.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, W'($urandom) | 8'h01, W'($urandom) | 8'h01, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_ovf", ovf, 0);
        q.delete();
        held = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle = cycle + 1;
        idle(S + 2);
        cyc(1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
        idle(S - 1);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_sum", sum, 8'h30);
        idle(2);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            cyc(($urandom % 4) != 0, W'($urandom), W'($urandom), 1'(($urandom)),
                1'(($urandom)), ($urandom % 3) != 0);
        idle(S + 3);
        chk("drained", q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
